// File: rtl/fib_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter fed by the Fibonacci block.
// Each clock performs one adjust+shift step; the result is registered and held.
module fib_bin2bcd #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  ready_o,
    output logic                  done_tick_o,
    output logic [4*DIGITS-1:0]   bcd_o
);
    localparam int NW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t              state_reg;
    logic [BIN_W-1:0]    bin_reg;
    logic [4*DIGITS-1:0] bcd_reg;
    logic [NW-1:0]       n_reg;
    logic [4*DIGITS-1:0] bcd_shf;

    // Per-digit +3 adjust folded directly into the one-bit left shift.
    // The top digit's carry-out would fall off the register, so it is never built.
    assign bcd_shf[0] = bin_reg[BIN_W-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic [3:0] d;
        logic       ge5;
        assign d   = bcd_reg[4*g +: 4];
        assign ge5 = (d >= 4'd5);
        if (g < DIGITS - 1) begin : g_full
            logic [3:0] a;
            assign a = ge5 ? d + 4'd3 : d;
            assign bcd_shf[4*g+1 +: 4] = a;
        end else begin : g_top
            logic [2:0] a;
            assign a = ge5 ? d[2:0] + 3'd3 : d[2:0];
            assign bcd_shf[4*g+1 +: 3] = a;
        end
    end

    assign ready_o     = (state_reg == IDLE);
    assign done_tick_o = (state_reg == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            n_reg     <= '0;
            bcd_o     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        bin_reg   <= bin_i;
                        bcd_reg   <= '0;
                        n_reg     <= NW'(BIN_W);
                        state_reg <= OP;
                    end
                end
                OP: begin
                    bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
                    bcd_reg <= bcd_shf;
                    n_reg   <= n_reg - NW'(1);
                    if (n_reg == NW'(1)) begin
                        bcd_o     <= bcd_shf;
                        state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_bin2bcd.sv
// Scoreboard bench: driver pushes model results, monitor pops on done_tick_o.
module tb_fib_bin2bcd;
    localparam int BIN_W  = 20;
    localparam int DIGITS = 7;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                start_i = 1'b0;
    logic [BIN_W-1:0]    bin_i = '0;
    logic                ready_o;
    logic                done_tick_o;
    logic [4*DIGITS-1:0] bcd_o;

    fib_bin2bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .bin_i       (bin_i),
        .ready_o     (ready_o),
        .done_tick_o (done_tick_o),
        .bcd_o       (bcd_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [4*DIGITS-1:0] exp_q[$];
    int                  acc_q[$];
    logic [4*DIGITS-1:0] held = '0;
    logic                prev_done = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference: decimal digits by repeated division.
    function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int unsigned fib(input int n);
        int unsigned a, b, t;
        a = 0; b = 1;
        for (int k = 0; k < n; k++) begin
            t = a + b; a = b; b = t;
        end
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every sampled cycle bcd_o must equal the last delivered result.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (prev_done) check("ready_after_done", 32'(ready_o), 32'd1);
            if (done_tick_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'(done_tick_o), 32'd0);
                end else begin
                    held = exp_q.pop_front();
                    check("bcd_value", 32'(bcd_o), 32'(held));
                    check("latency", 32'(cyc), 32'(acc_q.pop_front() + BIN_W));
                    check("ready_in_done", 32'(ready_o), 32'd0);
                end
            end else begin
                check("bcd_hold", 32'(bcd_o), 32'(held));
            end
            prev_done = done_tick_o;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Called one step after a rising edge; the following edge accepts.
    task automatic issue(input logic [BIN_W-1:0] v);
        start_i = 1'b1;
        bin_i   = v;
        exp_q.push_back(to_bcd(32'(v)));
        acc_q.push_back(cyc + 1);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        bin_i   = BIN_W'($urandom);
        check("busy_after_accept", 32'(ready_o), 32'd0);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk_i); #1;
        end
        if (exp_q.size() != 0) begin
            check("timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk_i); #1;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 40 && !done_tick_o; i++) begin
            @(posedge clk_i); #1;
        end
        if (!done_tick_o) check("done_timeout", 32'(done_tick_o), 32'd1);
    endtask

    initial begin
        #3;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_done", 32'(done_tick_o), 32'd0);
        check("rst_bcd", 32'(bcd_o), 32'd0);
        #9 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Directed corner values, including digit rollover and the maximum.
        issue(20'd0);       wait_empty();
        issue(20'd9);       wait_empty();
        issue(20'd10);      wait_empty();
        issue(20'd832040);  wait_empty();
        issue(20'd1048575); wait_empty();
        // Upstream chain: one done tick carrying F(20).
        issue(BIN_W'(fib(20))); wait_empty();

        // start during OP must be ignored.
        issue(20'd123456);
        repeat (5) @(posedge clk_i);
        #1 start_i = 1'b1; bin_i = 20'd999999;
        @(posedge clk_i); #1 start_i = 1'b0;
        wait_empty();

        // Start on the first IDLE cycle after DONE.
        issue(20'd500001);
        wait_done();
        @(posedge clk_i); #1;
        issue(20'd77);
        wait_empty();

        // Random values and random Fibonacci results.
        for (int k = 0; k < 12; k++) begin
            issue(BIN_W'($urandom_range(0, 1048575)));
            if ($urandom_range(0, 1) == 1) begin
                wait_done();
                @(posedge clk_i); #1;
            end else begin
                wait_empty();
            end
        end
        wait_empty();
        for (int k = 0; k < 6; k++) begin
            issue(BIN_W'(fib($urandom_range(0, 30))));
            wait_empty();
        end

        // Reset mid-conversion aborts with no done tick.
        issue(20'd654321);
        repeat (8) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        held = '0;
        check("abort_ready", 32'(ready_o), 32'd1);
        check("abort_done", 32'(done_tick_o), 32'd0);
        check("abort_bcd", 32'(bcd_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        repeat (30) @(posedge clk_i);
        #1;

        issue(20'd4321);
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
